// File: rtl/conv_window_gen.sv
// conv_window_gen
// ---------------
// Front end for the 5x5 convolution PE. It takes an 8-bit raster-order pixel
// stream and keeps four previous image lines in a line-buffer chain. It
// presents every complete 5x5 window (valid region only, stride 1) as a
// 200-bit word. Byte k = 5*r + c of win_out is pixel (row-4+r, col-4+c) of the
// pixel that completed the window, so byte k feeds PE input in_IF(k+1).
//
// Ports
//   clk        : clock
//   rst        : asynchronous, active-high reset
//   sof        : start of frame, meaningful only with pix_valid; the pixel is (0,0)
//   pix_valid  : pixel strobe
//   pix_in     : unsigned 8-bit pixel
//   win_valid  : one-cycle strobe per complete window
//   win_out    : 25 window bytes, byte k = win_out[8k+7:8k]
//   win_row    : top-left row of the presented window
//   win_col    : top-left column of the presented window
//   frame_done : pulses together with the last window of a frame
//
// Stream semantics: both sides are valid-only, with no ready signal. A pixel
// is consumed on every clock where pix_valid=1. A window is presented for
// exactly one clock when win_valid=1, one cycle after the pixel that completed
// it. Downstream must take it in that cycle.

module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [7:0]       pix_in,
  output logic             win_valid,
  output logic [199:0]     win_out,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             frame_done
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  // lb[0] holds the previous line and lb[3] the oldest one
  logic [7:0]       lb [4][IMG_W];
  logic [7:0]       win [5][5];
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] col;

  logic [CNT_W-1:0] cur_row;
  logic [CNT_W-1:0] cur_col;
  logic [AW-1:0]    addr;
  logic [7:0]       lb_rd [4];
  logic             win_ok;
  logic             last_pix;

  // sof overrides the counters, so a mid-frame restart takes effect on this pixel
  always_comb begin
    cur_row  = sof ? '0 : row;
    cur_col  = sof ? '0 : col;
    addr     = cur_col[AW-1:0];
    for (int i = 0; i < 4; i++) begin
      lb_rd[i] = lb[i][addr];
    end
    win_ok   = (cur_row >= CNT_W'(4)) && (cur_col >= CNT_W'(4));
    last_pix = (cur_row == CNT_W'(IMG_H - 1)) && (cur_col == CNT_W'(IMG_W - 1));
  end

  // Line-buffer RAM is not reset. Its contents only reach a valid window
  // after four full lines of the current frame have overwritten it.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb[0][addr] <= pix_in;
      for (int i = 1; i < 4; i++) begin
        lb[i][addr] <= lb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
      row        <= '0;
      col        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else if (pix_valid) begin
      // shift left one column and load the new right-hand column
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      win[4][4] <= pix_in;
      win[3][4] <= lb_rd[0];
      win[2][4] <= lb_rd[1];
      win[1][4] <= lb_rd[2];
      win[0][4] <= lb_rd[3];

      if (cur_col == CNT_W'(IMG_W - 1)) begin
        col <= '0;
        row <= (cur_row == CNT_W'(IMG_H - 1)) ? '0 : cur_row + CNT_W'(1);
      end else begin
        col <= cur_col + CNT_W'(1);
        row <= cur_row;
      end

      win_valid  <= win_ok;
      frame_done <= win_ok && last_pix;
      if (win_ok) begin
        win_row <= cur_row - CNT_W'(4);
        win_col <= cur_col - CNT_W'(4);
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  always_comb begin
    win_out = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_out[8*(5*r+c) +: 8] = win[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: an 8x6 instance runs the directed scenarios, and
// a default 28x28 instance gets random pixels with random gaps.
module tb_conv_window_gen;

  localparam int EW = 217; // {frame_done, row[7:0], col[7:0], window[199:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // small instance (8x6)
  logic         sof_s = 1'b0, pv_s = 1'b0;
  logic [7:0]   pix_s = '0;
  logic         wv_s, fd_s;
  logic [199:0] wo_s;
  logic [7:0]   wr_s, wc_s;

  // big instance (28x28)
  logic         sof_b = 1'b0, pv_b = 1'b0;
  logic [7:0]   pix_b = '0;
  logic         wv_b, fd_b;
  logic [199:0] wo_b;
  logic [7:0]   wr_b, wc_b;

  conv_window_gen #(.IMG_W(8), .IMG_H(6), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .sof(sof_s), .pix_valid(pv_s), .pix_in(pix_s),
    .win_valid(wv_s), .win_out(wo_s), .win_row(wr_s), .win_col(wc_s),
    .frame_done(fd_s)
  );

  conv_window_gen dut_b (
    .clk(clk), .rst(rst), .sof(sof_b), .pix_valid(pv_b), .pix_in(pix_b),
    .win_valid(wv_b), .win_out(wo_b), .win_row(wr_b), .win_col(wc_b),
    .frame_done(fd_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the whole current image per instance and cuts windows out of it.
  int         m_row [2];
  int         m_col [2];
  logic [7:0] img [2][28][28];
  bit         exp_v [2];
  logic [EW-1:0] exp_q_s[$];
  logic [EW-1:0] exp_q_b[$];

  task automatic model_step(input int id, input int w, input int h,
                            input bit s, input bit pv, input logic [7:0] p);
    int r, c;
    logic [199:0] ew;
    logic [EW-1:0] ent;
    exp_v[id] = 1'b0;
    if (pv) begin
      r = s ? 0 : m_row[id];
      c = s ? 0 : m_col[id];
      img[id][r][c] = p;
      if (r >= 4 && c >= 4) begin
        ew = '0;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            ew[8*(5*i+j) +: 8] = img[id][r-4+i][c-4+j];
        ent = {(r == h-1 && c == w-1), 8'(r-4), 8'(c-4), ew};
        exp_v[id] = 1'b1;
        if (id == 0) exp_q_s.push_back(ent);
        else         exp_q_b.push_back(ent);
      end
      c++;
      if (c == w) begin
        c = 0;
        r++;
        if (r == h) r = 0;
      end
      m_row[id] = r;
      m_col[id] = c;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_row[i] = 0; m_col[i] = 0; exp_v[i] = 1'b0;
      end
      exp_q_s.delete();
      exp_q_b.delete();
    end else begin
      model_step(0, 8, 6, sof_s, pv_s, pix_s);
      model_step(1, 28, 28, sof_b, pv_b, pix_b);
    end
  end

  // ---------------- compare process ----------------
  int cnt_s = 0, cnt_b = 0;
  int cap_idx = 0;
  logic [199:0] cap_win, last_win;
  logic [7:0]   cap_r, cap_c, last_r, last_c;
  logic         last_fd;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      check("win_valid_s", 200'(wv_s), 200'(exp_v[0]));
      if (wv_s) begin
        if (exp_q_s.size() == 0) begin
          check("unexpected_window_s", 200'(1), 200'(0));
        end else begin
          e = exp_q_s.pop_front();
          check("win_out_s", wo_s, e[199:0]);
          check("win_col_s", 200'(wc_s), 200'(e[207:200]));
          check("win_row_s", 200'(wr_s), 200'(e[215:208]));
          check("frame_done_s", 200'(fd_s), 200'(e[216]));
        end
        if (cnt_s == cap_idx) begin
          cap_win = wo_s; cap_r = wr_s; cap_c = wc_s;
        end
        last_win = wo_s; last_r = wr_s; last_c = wc_s; last_fd = fd_s;
        cnt_s++;
      end else begin
        check("frame_done_idle_s", 200'(fd_s), 200'(0));
      end

      check("win_valid_b", 200'(wv_b), 200'(exp_v[1]));
      if (wv_b) begin
        if (exp_q_b.size() == 0) begin
          check("unexpected_window_b", 200'(1), 200'(0));
        end else begin
          e = exp_q_b.pop_front();
          check("win_out_b", wo_b, e[199:0]);
          check("win_col_b", 200'(wc_b), 200'(e[207:200]));
          check("win_row_b", 200'(wr_b), 200'(e[215:208]));
          check("frame_done_b", 200'(fd_b), 200'(e[216]));
        end
        cnt_b++;
      end else begin
        check("frame_done_idle_b", 200'(fd_b), 200'(0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: pixel = 16r+c, mode 1: pixel = 0xFF-(16r+c)
  task automatic feed_s(input int mode, input bit toggle, input int npix);
    int r, c;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / 8;
      c = idx % 8;
      @(negedge clk);
      sof_s = (idx == 0);
      pv_s  = 1'b1;
      pix_s = (mode == 0) ? 8'(16*r + c) : 8'(8'hFF - (16*r + c));
      if (toggle) begin
        @(negedge clk);
        pv_s  = 1'b0;
        sof_s = 1'($urandom_range(0, 1));
        pix_s = 8'($urandom);
      end
    end
  endtask

  task automatic idle_s(input int n);
    repeat (n) begin
      @(negedge clk);
      pv_s = 1'b0;
      sof_s = 1'b0;
      pix_s = 8'($urandom);
    end
  endtask

  task automatic check_small_frame(input string tag);
    check({tag, "_count"}, 200'(cnt_s), 200'(8));
    check({tag, "_first_row"}, 200'(cap_r), 200'(0));
    check({tag, "_first_col"}, 200'(cap_c), 200'(0));
    check({tag, "_first_b0"}, 200'(cap_win[7:0]), 200'(8'h00));
    check({tag, "_first_b24"}, 200'(cap_win[199:192]), 200'(8'h44));
    check({tag, "_last_row"}, 200'(last_r), 200'(1));
    check({tag, "_last_col"}, 200'(last_c), 200'(3));
    check({tag, "_last_b0"}, 200'(last_win[7:0]), 200'(8'h13));
    check({tag, "_last_b24"}, 200'(last_win[199:192]), 200'(8'h57));
    check({tag, "_last_fd"}, 200'(last_fd), 200'(1));
    check({tag, "_queue_empty"}, 200'(exp_q_s.size()), 200'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_win_valid", 200'(wv_s), 200'(0));
    check("rst_frame_done", 200'(fd_s), 200'(0));
    check("rst_win_out", wo_s, 200'(0));
    check("rst_win_row", 200'(wr_s), 200'(0));
    check("rst_win_col", 200'(wc_s), 200'(0));
    @(negedge clk);
    rst = 1'b0;

    // continuous frame
    cnt_s = 0; cap_idx = 0;
    feed_s(0, 1'b0, 48);
    idle_s(3);
    check_small_frame("cont");

    // pix_valid toggling every cycle
    cnt_s = 0; cap_idx = 0;
    feed_s(0, 1'b1, 48);
    idle_s(3);
    check_small_frame("toggle");

    // two frames back to back, second one inverted
    cnt_s = 0; cap_idx = 8;
    feed_s(0, 1'b0, 48);
    feed_s(1, 1'b0, 48);
    idle_s(3);
    check("b2b_count", 200'(cnt_s), 200'(16));
    check("b2b_f2_b0", 200'(cap_win[7:0]), 200'(8'hFF));
    check("b2b_f2_b24", 200'(cap_win[199:192]), 200'(8'hBB));
    check("b2b_f2_row", 200'(cap_r), 200'(0));
    check("b2b_f2_col", 200'(cap_c), 200'(0));

    // restart with sof at row 3, col 2
    cnt_s = 0; cap_idx = 0;
    feed_s(0, 1'b0, 3*8 + 2);
    feed_s(0, 1'b0, 48);
    idle_s(3);
    check_small_frame("sof_restart");

    // reset at row 5, col 5 while a window is being presented
    feed_s(0, 1'b0, 5*8 + 5);
    @(negedge clk);
    pv_s = 1'b0;
    sof_s = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_win_valid", 200'(wv_s), 200'(0));
    check("midrst_frame_done", 200'(fd_s), 200'(0));
    check("midrst_win_out", wo_s, 200'(0));
    @(negedge clk);
    rst = 1'b0;
    cnt_s = 0; cap_idx = 0;
    feed_s(0, 1'b0, 48);
    idle_s(3);
    check_small_frame("after_rst");

    // 28x28 frame with random pixels and random gaps
    cnt_b = 0;
    for (int idx = 0; idx < 28*28; idx++) begin
      while ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        pv_b = 1'b0;
        sof_b = 1'($urandom_range(0, 1));
        pix_b = 8'($urandom);
      end
      @(negedge clk);
      pv_b = 1'b1;
      sof_b = (idx == 0);
      pix_b = 8'($urandom);
    end
    @(negedge clk);
    pv_b = 1'b0;
    sof_b = 1'b0;
    repeat (3) @(negedge clk);
    check("big_count", 200'(cnt_b), 200'(576));
    check("big_queue_empty", 200'(exp_q_b.size()), 200'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 5x5 convolution PE.
- Accepts an unsigned 8-bit feature-map stream in raster order, one pixel per cycle when pix_valid is high.
- Buffers 4 full image lines plus the current line and presents each complete 5x5 window as 25 bytes, which map directly onto the PE in_IF1..in_IF25 inputs.
- Produces only "valid" windows (no padding), with stride 1.

Parameters:
- IMG_W, 28, image width in pixels (>=5).
- IMG_H, 28, image height in pixels (>=5).
- CNT_W, 8, width of the row/column counters and coordinate outputs; 2^CNT_W must exceed max(IMG_W, IMG_H).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- sof  in  1  start-of-frame; qualified by pix_valid; marks the current pixel as (0,0).
- pix_valid  in  1  pixel strobe.
- pix_in  in  8  unsigned pixel.
- win_valid  out  1  window strobe, one cycle per window.
- win_out  out  200  window; byte k = win_out[8k+7:8k], k=5r+c, is pixel (row-4+r, col-4+c). Byte k drives PE in_IF(k+1).
- win_row  out  CNT_W  top-left row of the presented window.
- win_col  out  CNT_W  top-left column of the presented window.
- frame_done  out  1  one-cycle pulse with the last window of the frame.

Behaviour:
- Reset values: win_valid=0, frame_done=0, win_out=0, win_row=0, win_col=0.
  - Internal row/col counters are 0 and the window registers are 0.
  - Line-buffer RAM contents are not reset; they are never exposed, see the validity rule below.
- Storage:
  - 4 line buffers, each IMG_W x 8, organised as a chain: lb0 holds the previous line, lb3 the oldest.
  - 5x5 window register array.
- On an accepted pixel (pix_valid=1), at (row, col):
  - Read column col from lb0..lb3.
  - Shift the window left by one column.
  - Load the new right column: r=4 from pix_in, r=3 from lb0, r=2 from lb1, r=1 from lb2, r=0 from lb3.
  - Write pix_in to lb0[col], lb0[col] to lb1[col], and so on down the chain (shift-through).
  - Advance counters: col++. At col==IMG_W-1, col wraps to 0 and row++. At row==IMG_H-1 && col==IMG_W-1, both wrap to 0.
- Validity rule: the window is valid when the accepted pixel has row>=4 and col>=4.
  - win_valid pulses 1 cycle after that pixel is accepted (registered output, latency 1).
  - win_row = row-4 and win_col = col-4 of that pixel.
- frame_done:
  - Pulses in the same cycle as the win_valid for pixel (IMG_H-1, IMG_W-1).
  - Windows per frame = (IMG_W-4)*(IMG_H-4).
- pix_valid=0: nothing shifts. Counters, window and line buffers hold. win_valid=0 in the following cycle; win_out holds its last value.
- sof=1 with pix_valid=1: the pixel is treated as (0,0) regardless of the counters. Mid-frame sof abandons the partial frame, and no window is emitted for it until row>=4 again. sof with pix_valid=0 is ignored.
- Back-to-back frames: counter wrap and the next pixel are contiguous, with no bubble required.
- rst asserted mid-frame: all outputs go to their reset values immediately. The next accepted pixel is (0,0).
- No backpressure: downstream must accept one window per cycle. Cadence with pix_valid continuously high: IMG_W-4 consecutive valid windows per row, then a 4-cycle gap.

Test Plan:
- IMG_W=8, IMG_H=6, pixel = 16*row+col, pix_valid always 1 -> exactly 8 win_valid pulses.
  - First window has win_row=0, win_col=0, bytes k=5r+c equal to 16r+c (byte 0 = 0x00, byte 24 = 0x44).
  - Last window has win_row=1, win_col=3, byte 0 = 0x13, byte 24 = 0x57, with frame_done=1.
- Same image with pix_valid toggling 1/0 each cycle -> identical window contents and order. No win_valid in the cycle after a pix_valid=0 cycle.
- Two frames back-to-back, the second with pixel = 0xFF-(16r+c) -> 16 windows total. The second frame's first window has byte 0 = 0xFF and byte 24 = 0xBB, with no stale data from frame 1.
- sof reasserted at row 3, col 2 of frame 1, then a full image -> no window until the new row 4, col 4. Then the 8 correct windows.
- rst pulsed at row 5, col 5 -> win_valid, frame_done and win_out are 0 immediately. The next full frame produces the same 8 windows as the first test.
- Default IMG_W=28, IMG_H=28 with random pixels -> 576 windows, each compared against a reference model.
